// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: divider state encoding and iteration count.
package mips_pkg;

    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned DIV_CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor always holds, so the shifted value and the signed difference fit WIDTH+1 bits.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, div_i};
        if (!diff[WIDTH]) begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage: stalls the pipeline during a
// restoring division and writes quotient/remainder to HI/LO with a one-cycle strobe.
module div_seq
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_CYCLES
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    div_state_t             state_q, state_d;
    logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic [WIDTH-1:0]       quo_q, quo_d;
    logic [WIDTH-1:0]       div_q, div_d;
    logic                   neg_quo_q, neg_quo_d;
    logic                   neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;

    logic [WIDTH-1:0]       step_rem;
    logic [WIDTH-1:0]       step_quo;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i(rem_q),
        .quo_i(quo_q),
        .div_i(div_q),
        .rem_o(step_rem),
        .quo_o(step_quo)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (b != '0) begin
                            rem_d     = '0;
                            quo_d     = (is_signed && a[WIDTH-1]) ? -a : a;
                            div_d     = (is_signed && b[WIDTH-1]) ? -b : b;
                            neg_quo_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem_d = is_signed && a[WIDTH-1];
                            cnt_d     = '0;
                            state_d   = CALC;
                        end else begin
                            hi_d    = a;
                            lo_d    = '1;
                            state_d = DONE;
                        end
                    end
                end
                CALC: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == DIV_CNT_W'(WIDTH - 1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    lo_d    = neg_quo_q ? -quo_q : quo_q;
                    hi_d    = neg_rem_q ? -rem_q : rem_q;
                    state_d = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // resetn gates stall so a held start cannot freeze the pipeline while in reset.
    assign stall   = resetn && !flush &&
                     ((state_q == IDLE && start) || state_q == CALC || state_q == FIX);
    assign done    = (state_q == DONE);
    assign hilo_we = (state_q == DONE);
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed scoreboard bench for div_seq: latency, stall window, HI/LO results, flush and reset.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        done;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    div_seq #(
        .WIDTH(32)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .start(start),
        .is_signed(is_signed),
        .a(a),
        .b(b),
        .flush(flush),
        .stall(stall),
        .done(done),
        .hilo_we(hilo_we),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one request at the next negedge and follows it to its done pulse.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] ta,
                           input logic [31:0] tb_, input int lat,
                           input logic [31:0] ehi, input logic [31:0] elo);
        int          c;
        int          stalls;
        logic        seen;
        logic        we_mis;
        logic [63:0] e;
        exp_q.push_back({ehi, elo});
        @(negedge clk);
        chk({tag, ":hold_hi"}, hi, last_hi);
        chk({tag, ":hold_lo"}, lo, last_lo);
        resetn    = 1'b1;
        start     = 1'b1;
        is_signed = sgn;
        a         = ta;
        b         = tb_;
        stalls    = 0;
        seen      = 1'b0;
        we_mis    = 1'b0;
        for (c = 0; c <= lat + 20; c++) begin
            #1;
            if (hilo_we !== done) we_mis = 1'b1;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (stall === 1'b1) stalls++;
            @(negedge clk);
        end
        chk({tag, ":done_seen"}, 32'(seen), 32'd1);
        chk({tag, ":latency"}, c, lat);
        chk({tag, ":stall_cycles"}, stalls, lat);
        chk({tag, ":stall_at_done"}, 32'(stall), 32'd0);
        chk({tag, ":we_eq_done"}, 32'(we_mis), 32'd0);
        start = 1'b0;
        e = exp_q.pop_front();
        chk({tag, ":hi"}, hi, e[63:32]);
        chk({tag, ":lo"}, lo, e[31:0]);
        last_hi = e[63:32];
        last_lo = e[31:0];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we_seen;
        logic [31:0] ra, rb, mq, mr;
        logic        rs;

        resetn    = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        flush     = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        a     = 32'd5;
        b     = 32'd1;
        #1;
        chk("rst:stall", 32'(stall), 32'd0);
        chk("rst:done", 32'(done), 32'd0);
        chk("rst:hilo_we", 32'(hilo_we), 32'd0);
        chk("rst:hi", hi, 32'd0);
        chk("rst:lo", lo, 32'd0);
        start = 1'b0;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 34, 32'd2, 32'd14);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000);
        run_div("divu_by0", 1'b0, 32'h0000_1234, 32'd0, 1, 32'h0000_1234, 32'hFFFF_FFFF);
        run_div("div_by0_s", 1'b1, 32'h8765_4321, 32'd0, 1, 32'h8765_4321, 32'hFFFF_FFFF);
        run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'd1, 34, 32'd0, 32'hFFFF_FFFF);

        // Flush during CALC at cycle 10, start held until the flush.
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        a         = 32'd100;
        b         = 32'd7;
        we_seen   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (hilo_we === 1'b1) we_seen = 1'b1;
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        chk("flush:stall_c10", 32'(stall), 32'd0);
        chk("flush:we_c10", 32'(hilo_we), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        #1;
        chk("flush:stall_c11", 32'(stall), 32'd0);
        chk("flush:done_c11", 32'(done), 32'd0);
        chk("flush:we_before", 32'(we_seen), 32'd0);
        chk("flush:hi_kept", hi, last_hi);
        chk("flush:lo_kept", lo, last_lo);
        run_div("after_flush", 1'b0, 32'd100, 32'd7, 34, 32'd2, 32'd14);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 32'd0) rb = 32'd3;
            rs = i[0];
            if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) ra = 32'd1;
            if (rs) begin
                mq = $signed(ra) / $signed(rb);
                mr = $signed(ra) % $signed(rb);
            end else begin
                mq = ra / rb;
                mr = ra % rb;
            end
            run_div($sformatf("rand%0d", i), rs, ra, rb, 34, mr, mq);
        end

        // Reset pulse at cycle 20 of a divide; start stays high through release.
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        a         = 32'd1000;
        b         = 32'd3;
        for (int c = 0; c < 20; c++) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rstmid:stall", 32'(stall), 32'd0);
        chk("rstmid:done", 32'(done), 32'd0);
        chk("rstmid:hilo_we", 32'(hilo_we), 32'd0);
        chk("rstmid:hi", hi, 32'd0);
        chk("rstmid:lo", lo, 32'd0);
        last_hi = '0;
        last_lo = '0;
        run_div("after_rst", 1'b0, 32'd1000, 32'd3, 34, 32'd1, 32'd333);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle sequencer for MIPS32 DIV/DIVU in the EX stage. It accepts a divide request from the decoded instruction and runs a 32-iteration restoring division. While the division runs, it drives the pipeline stall that deasserts the enables of the IF/ID/EX pipeline registers. On completion it presents quotient and remainder to the HI/LO register file with a one-cycle write strobe.

## Interface
Parameters
- WIDTH, 32: operand width; the iteration count equals WIDTH.

Ports
- clk  in  1  rising-edge clock.
- resetn  in  1  reset, asynchronous, active-low; returns the block to IDLE.
- start  in  1  EX holds a valid DIV/DIVU; held high by the stalled pipeline until `done`.
- is_signed  in  1  1 = DIV, 0 = DIVU; sampled with start in IDLE.
- a  in  WIDTH  dividend; sampled in IDLE.
- b  in  WIDTH  divisor; sampled in IDLE.
- flush  in  1  exception/branch cancel; aborts any operation.
- stall  out  1  1 = hold pipeline register enables low.
- done  out  1  one-cycle completion pulse.
- hilo_we  out  1  HI/LO write strobe; equals done.
- hi  out  WIDTH  remainder; held until the next completion.
- lo  out  WIDTH  quotient; held until the next completion.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start && !flush && b!=0: latch |a|, |b| (signed mode) or a, b; latch the sign flags; clear the 6-bit counter; go to CALC.
  - start && !flush && b==0: go to DONE with lo=all ones, hi=a.
- CALC, one iteration per cycle:
  - Shift {rem[WIDTH:0], quo} left by 1.
  - Trial subtract of the divisor from rem. If the result is non-negative, keep it and set quo[0]=1.
  - After WIDTH iterations (counter == WIDTH-1), go to FIX.
- FIX:
  - Signed mode only: negate quo if the operand signs differ, and negate rem if the dividend is negative.
  - Load hi/lo; go to DONE.
- DONE: done=hilo_we=1 for one cycle; go to IDLE unconditionally. A start seen in DONE belongs to the retiring instruction and is ignored.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
- stall = !flush && ((state==IDLE && start) || state==CALC || state==FIX). stall is 0 in DONE so the instruction retires that cycle.
- flush in any state: next state IDLE, no hilo_we, hi/lo unchanged. stall is forced 0 in the flush cycle.
- Reset values: state=IDLE, stall=0, done=0, hilo_we=0, hi=0, lo=0, counter=0.

## Timing
- Normal divide: start seen in IDLE at cycle 0.
  - CALC runs cycles 1–32, FIX cycle 33, DONE cycle 34.
  - stall is high cycles 0–33 (34 cycles).
  - done/hilo_we are high cycle 34.
  - hi/lo become valid at cycle 34 and hold.
- Divide by zero: start at cycle 0, DONE at cycle 1. stall high cycle 0 only.
- Back-to-back divides: the second start is accepted in the IDLE cycle following DONE (cycle 35). No overlap.
- resetn asserted mid-operation: immediate return to IDLE with all outputs at reset values. No hilo_we.
- stall is combinational from start/flush/state. All other outputs are registered.

## Structure
- Shared package mips_pkg: state enum div_state_t (IDLE, CALC, FIX, DONE), constant DIV_CYCLES = 32.
- One sub-module: div_step (combinational shift/trial-subtract of one iteration).
- State register, counter and operand/result registers stay in div_seq.

## Test plan
- DIVU a=100, b=7, start at cycle 0 -> stall high 34 cycles; cycle 34 done=hilo_we=1, lo=14, hi=2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at cycle 34.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, no error.
- DIVU a=0x1234, b=0 -> done at cycle 1, lo=0xFFFFFFFF, hi=0x1234; stall only in cycle 0.
- DIVU 100/7, flush at cycle 10 -> IDLE at cycle 11, stall 0 from cycle 10, no hilo_we, hi/lo keep previous values. A following start at cycle 12 completes normally at cycle 46.
- resetn pulsed low at cycle 20 of a divide -> outputs 0 immediately. After release with start held, a fresh 34-cycle divide runs.
